// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg
//   Shared definitions for the bus_timer_slave peripheral: register word
//   offsets, CTRL/STAT bit positions and the timer state encoding.
//   Optional feature macro used by the design: BUS_TIMER_IRQ_EN.
package bus_timer_pkg;

  localparam logic [2:0] OFS_CTRL = 3'd0;
  localparam logic [2:0] OFS_PSC  = 3'd1;
  localparam logic [2:0] OFS_ARR  = 3'd2;
  localparam logic [2:0] OFS_CNT  = 3'd3;
  localparam logic [2:0] OFS_STAT = 3'd4;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_CLR         = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int CTRL_AUTO_RELOAD = 3;

  localparam int STAT_MATCH = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/bus_timer_slave_prescaler.sv
// timer_prescaler
//   Divides the clock by (psc + 1) while en is high. tick is asserted in the
//   cycle where the internal count equals psc; the count then returns to 0.
//   restart forces the count to 0 on the next edge regardless of en.
// Ports
//   clk      system clock
//   rst      asynchronous active-low reset
//   en       count enable (held count when low)
//   psc      divide value minus one
//   restart  synchronous clear of the prescale count
//   tick     combinational terminal-count strobe
module timer_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  input  logic             restart,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt_q;
  logic [PSC_W-1:0] psc_cnt_d;

  assign tick = en && (psc_cnt_q == psc);

  always_comb begin
    psc_cnt_d = psc_cnt_q;
    if (restart) begin
      psc_cnt_d = '0;
    end else if (en) begin
      psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/bus_timer_slave.sv
// bus_timer_slave
//   Memory-mapped prescaled up-counter with compare, optional auto-reload,
//   sticky match flag and optional level interrupt.
//   Word map (busAddr[4:2]): 0 CTRL, 1 PSC, 2 ARR, 3 CNT (ro), 4 STAT (w1c);
//   other offsets read 0 and ignore writes.
//   Optional feature macro: BUS_TIMER_IRQ_EN. When undefined, CTRL.IRQ_EN is
//   not stored and irq is tied low.
// Ports
//   clk       system clock
//   rst       asynchronous active-low reset
//   sel       block select from the address decoder
//   busWe     write strobe, qualified by sel
//   busAddr   byte address, only [4:2] decoded
//   busWData  write data
//   busRData  combinational read data, 0 when not selected
//   irq       registered level interrupt, active high
module bus_timer_slave
  import bus_timer_pkg::*;
#(
  parameter int PSC_W = 16,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        irq
);

  timer_state_e     state_q, state_d;
  logic             en_q, en_d;
  logic             auto_reload_q, auto_reload_d;
  logic             irq_en_q;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] arr_q, arr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;

  logic [2:0] ofs;
  logic       wr_ctrl, wr_psc, wr_arr, wr_stat;
  logic       clr, stop_wr, run, tick, tick_eff, match_ev, oneshot_end;
  logic       unused_addr;

  assign ofs         = busAddr[4:2];
  assign unused_addr = ^{busAddr[31:5], busAddr[1:0]};

  assign wr_ctrl = sel && busWe && (ofs == OFS_CTRL);
  assign wr_psc  = sel && busWe && (ofs == OFS_PSC);
  assign wr_arr  = sel && busWe && (ofs == OFS_ARR);
  assign wr_stat = sel && busWe && (ofs == OFS_STAT);

  assign clr     = wr_ctrl && busWData[CTRL_CLR];
  // A write clearing EN takes priority over a tick landing on the same edge.
  assign stop_wr = wr_ctrl && !busWData[CTRL_EN];
  assign run     = (state_q == RUN) && !stop_wr;

  timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (run),
    .psc     (psc_q),
    .restart (wr_psc || clr),
    .tick    (tick)
  );

  // CLR overrides a same-cycle tick: no count, no match.
  assign tick_eff    = tick && !clr;
  assign match_ev    = tick_eff && (cnt_q == arr_q);
  assign oneshot_end = match_ev && !auto_reload_q && !wr_ctrl;

  always_comb begin
    en_d          = en_q;
    auto_reload_d = auto_reload_q;
    psc_d         = psc_q;
    arr_d         = arr_q;
    cnt_d         = cnt_q;
    match_d       = match_q;
    state_d       = state_q;

    if (wr_ctrl) begin
      en_d          = busWData[CTRL_EN];
      auto_reload_d = busWData[CTRL_AUTO_RELOAD];
    end else if (oneshot_end) begin
      en_d = 1'b0;
    end

    if (wr_psc) psc_d = busWData[PSC_W-1:0];
    if (wr_arr) arr_d = busWData[CNT_W-1:0];

    if (clr) begin
      cnt_d = '0;
    end else if (tick_eff) begin
      cnt_d = match_ev ? '0 : cnt_q + CNT_W'(1);
    end

    // Hardware set beats a software clear in the same cycle.
    if (match_ev) begin
      match_d = 1'b1;
    end else if (wr_stat && busWData[STAT_MATCH]) begin
      match_d = 1'b0;
    end

    case (state_q)
      IDLE, DONE: if (en_d) state_d = RUN;
      RUN:        if (!en_d) state_d = oneshot_end ? DONE : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      auto_reload_q <= 1'b0;
      psc_q         <= '0;
      arr_q         <= '0;
      cnt_q         <= '0;
      match_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      auto_reload_q <= auto_reload_d;
      psc_q         <= psc_d;
      arr_q         <= arr_d;
      cnt_q         <= cnt_d;
      match_q       <= match_d;
    end
  end

`ifdef BUS_TIMER_IRQ_EN
  logic irq_en_d;
  logic irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_ctrl) irq_en_d = busWData[CTRL_IRQ_EN];
    irq_d = match_q && irq_en_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    busRData = '0;
    if (sel) begin
      case (ofs)
        OFS_CTRL: begin
          busRData[CTRL_EN]          = en_q;
          busRData[CTRL_IRQ_EN]      = irq_en_q;
          busRData[CTRL_AUTO_RELOAD] = auto_reload_q;
        end
        OFS_PSC:  busRData[PSC_W-1:0] = psc_q;
        OFS_ARR:  busRData[CNT_W-1:0] = arr_q;
        OFS_CNT:  busRData[CNT_W-1:0] = cnt_q;
        OFS_STAT: busRData[STAT_MATCH] = match_q;
        default:  busRData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer_slave.sv
// Testbench for bus_timer_slave. Expected values are queued when a check is
// issued and popped when the DUT output is sampled. Honours BUS_TIMER_IRQ_EN.
module tb_bus_timer_slave;

`ifdef BUS_TIMER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        sel;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb_q[$];

  bus_timer_slave #(.PSC_W(16), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .busWe    (busWe),
    .busAddr  (busAddr),
    .busWData (busWData),
    .busRData (busRData),
    .irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input logic [31:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ofs, input logic [31:0] data);
    sel      = 1'b1;
    busWe    = 1'b1;
    busAddr  = {27'd0, ofs, 2'b00};
    busWData = data;
    @(posedge clk);
    #1;
    sel      = 1'b0;
    busWe    = 1'b0;
    busWData = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] ofs, input logic [31:0] exp,
                    input bit s = 1'b1);
    logic [31:0] obs;
    push_exp(tag, exp);
    sel     = s;
    busWe   = 1'b0;
    busAddr = {27'd0, ofs, 2'b00};
    #1;
    obs = busRData;
    sel = 1'b0;
    compare(obs);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    push_exp(tag, {31'd0, exp});
    compare({31'd0, irq});
  endtask

  logic [31:0] exp_cnt2  [5];
  logic [31:0] exp_stat2 [5];
  logic [31:0] exp_cnt3  [6];
  logic [31:0] exp_stat3 [6];
  logic [31:0] exp_ctrl3 [6];

  initial begin
    exp_cnt2  = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    exp_stat2 = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
    exp_cnt3  = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0};
    exp_stat3 = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    exp_ctrl3 = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0};

    rst      = 1'b0;
    sel      = 1'b0;
    busWe    = 1'b0;
    busAddr  = '0;
    busWData = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick_n(1);

    // Reset state
    rd("rst_ctrl", 3'd0, 32'd0);
    rd("rst_psc",  3'd1, 32'd0);
    rd("rst_arr",  3'd2, 32'd0);
    rd("rst_cnt",  3'd3, 32'd0);
    rd("rst_stat", 3'd4, 32'd0);
    chk_irq("rst_irq", 1'b0);

    // Auto-reload, PSC=0, ARR=3
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd3);
    wr(3'd0, 32'h9);
    rd("ar_cnt_start", 3'd3, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick_n(1);
      rd($sformatf("ar_cnt_%0d", i), 3'd3, exp_cnt2[i]);
      rd($sformatf("ar_stat_%0d", i), 3'd4, exp_stat2[i]);
    end
    rd("ar_ctrl", 3'd0, 32'h9);

    // One-shot, PSC=2, ARR=1
    wr(3'd0, 32'h0);
    wr(3'd0, 32'h2);
    wr(3'd4, 32'h1);
    rd("os_stat_clr", 3'd4, 32'd0);
    rd("os_cnt_clr",  3'd3, 32'd0);
    wr(3'd1, 32'd2);
    wr(3'd2, 32'd1);
    wr(3'd0, 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick_n(1);
      rd($sformatf("os_cnt_%0d", i),  3'd3, exp_cnt3[i]);
      rd($sformatf("os_stat_%0d", i), 3'd4, exp_stat3[i]);
      rd($sformatf("os_ctrl_%0d", i), 3'd0, exp_ctrl3[i]);
    end
    tick_n(2);
    rd("os_cnt_hold",  3'd3, 32'd0);
    rd("os_ctrl_hold", 3'd0, 32'd0);
    rd("os_stat_hold", 3'd4, 32'd1);

    // Match set and W1C in the same cycle: set wins
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd3);
    wr(3'd0, 32'h9);
    tick_n(3);
    rd("w1c_cnt_pre", 3'd3, 32'd3);
    wr(3'd4, 32'h1);
    rd("w1c_collide_stat", 3'd4, 32'd1);
    rd("w1c_collide_cnt",  3'd3, 32'd0);
    wr(3'd4, 32'h1);
    rd("w1c_clean_stat", 3'd4, 32'd0);
    rd("w1c_clean_cnt",  3'd3, 32'd1);

    // Interrupt path, one-shot ARR=2
    wr(3'd0, 32'h0);
    wr(3'd0, 32'h2);
    wr(3'd4, 32'h1);
    rd("irq_stat_clr", 3'd4, 32'd0);
    chk_irq("irq_idle", 1'b0);
    wr(3'd2, 32'd2);
    wr(3'd0, 32'h5);
    rd("irq_ctrl_run", 3'd0, IRQ_ON ? 32'h5 : 32'h1);
    tick_n(3);
    rd("irq_stat_match", 3'd4, 32'd1);
    rd("irq_cnt_match",  3'd3, 32'd0);
    rd("irq_ctrl_done",  3'd0, IRQ_ON ? 32'h4 : 32'h0);
    chk_irq("irq_same_cycle", 1'b0);
    tick_n(1);
    chk_irq("irq_next_cycle", IRQ_ON);
    wr(3'd4, 32'h1);
    rd("irq_stat_w1c", 3'd4, 32'd0);
    tick_n(1);
    chk_irq("irq_after_w1c", 1'b0);

    // Read-only CNT, unmapped offsets, deselected read
    wr(3'd3, 32'hFFFF);
    rd("ro_cnt", 3'd3, 32'd0);
    for (int o = 5; o < 8; o++) begin
      wr(3'(o), 32'hFFFF_FFFF);
      rd($sformatf("unmapped_%0d", o), 3'(o), 32'd0);
    end
    rd("arr_intact", 3'd2, 32'd2);
    rd("psc_intact", 3'd1, 32'd0);
    rd("desel_arr",  3'd2, 32'd0, 1'b0);

    // Reset mid-run with CNT=0x55
    wr(3'd2, 32'h100);
    wr(3'd0, 32'h5);
    tick_n(32'h55);
    rd("mid_cnt", 3'd3, 32'h55);
    rst = 1'b0;
    #1;
    rd("mrst_cnt",  3'd3, 32'd0);
    rd("mrst_stat", 3'd4, 32'd0);
    rd("mrst_ctrl", 3'd0, 32'd0);
    rd("mrst_arr",  3'd2, 32'd0);
    chk_irq("mrst_irq", 1'b0);
    tick_n(1);
    rst = 1'b1;
    tick_n(3);
    rd("post_rst_cnt", 3'd3, 32'd0);
    chk_irq("post_rst_irq", 1'b0);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
